mem_line_responder: RTL and testbench

//  Memory-side responder for the cache line-fill protocol: accepts single-line (128b) read/write

---
 rtl/mem_line_responder_pkg.sv | 19 +
 rtl/mem_line_responder_array.sv | 23 ++
 rtl/mem_line_responder.sv | 131 +++++++++++++
 tb/tb_mem_line_responder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_line_responder_pkg.sv
// Shared types and defaults for the cache line-fill memory responder.
package mem_line_responder_pkg;

  localparam int unsigned MEM_ADDR_W = 28;
  localparam int unsigned MEM_LINE_W = 128;
  localparam int unsigned CNT_W      = 8;

  typedef enum logic [1:0] {
    MR_IDLE,
    MR_BUSY,
    MR_RESP,
    MR_GAP
  } mr_state_e;

  function automatic logic [CNT_W-1:0] lat_load(input int unsigned lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/mem_line_responder_array.sv
// Single-port synchronous line store; contents are not reset, read data holds until the next read.
module mem_line_array #(
  parameter int unsigned LINE_W = 128,
  parameter int unsigned IDX_W  = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  idx,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** IDX_W;

  logic [LINE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/mem_line_responder.sv
// Memory-side line-fill responder: accepts one line request, waits a fixed latency,
// pulses mem_ready once, then ignores requests for a turnaround window.
module mem_line_responder
  import mem_line_responder_pkg::*;
#(
  parameter int unsigned ADDR_W     = MEM_ADDR_W,
  parameter int unsigned LINE_W     = MEM_LINE_W,
  parameter int unsigned IDX_W      = 8,
  parameter int unsigned RD_LAT     = 4,
  parameter int unsigned WR_LAT     = 4,
  parameter int unsigned TURNAROUND = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0] mem_wdata,
  output logic              mem_ready,
  output logic [LINE_W-1:0] mem_rdata,
  output logic              proto_err
);

  mr_state_e         state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [CNT_W-1:0]  gcnt, gcnt_nx;
  logic              op_rd;
  logic [IDX_W-1:0]  idx_q;
  logic [LINE_W-1:0] wdata_q;
  logic              has_rdata;
  logic              accept;
  logic              ram_we, ram_re;
  logic [IDX_W-1:0]  ram_idx;
  logic [LINE_W-1:0] ram_rdata;
  logic              addr_unused;

  // Upper address bits alias onto the same lines by design.
  assign addr_unused = ^mem_addr[ADDR_W-1:IDX_W];

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    gcnt_nx  = gcnt;
    accept   = 1'b0;
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    ram_idx  = idx_q;
    case (state)
      MR_IDLE: begin
        if (mem_read || mem_write) begin
          accept  = 1'b1;
          ram_idx = mem_addr[IDX_W-1:0];
          if (mem_read) begin
            cnt_nx = lat_load(RD_LAT);
            if (RD_LAT == 1) begin
              state_nx = MR_RESP;
              ram_re   = 1'b1;
            end else begin
              state_nx = MR_BUSY;
            end
          end else begin
            cnt_nx   = lat_load(WR_LAT);
            state_nx = (WR_LAT == 1) ? MR_RESP : MR_BUSY;
          end
        end
      end
      MR_BUSY: begin
        // The accept edge counts as the first decrement, so leave BUSY when the count reaches zero.
        cnt_nx = cnt - CNT_W'(1);
        if (cnt_nx == '0) begin
          state_nx = MR_RESP;
          ram_re   = op_rd;
        end
      end
      MR_RESP: begin
        ram_we = ~op_rd;
        if (TURNAROUND == 0) begin
          state_nx = MR_IDLE;
        end else begin
          state_nx = MR_GAP;
          gcnt_nx  = lat_load(TURNAROUND);
        end
      end
      MR_GAP: begin
        if (gcnt == '0) state_nx = MR_IDLE;
        else            gcnt_nx  = gcnt - CNT_W'(1);
      end
      default: state_nx = MR_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= MR_IDLE;
      cnt       <= '0;
      gcnt      <= '0;
      op_rd     <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      has_rdata <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      gcnt  <= gcnt_nx;
      if (accept) begin
        op_rd   <= mem_read;
        idx_q   <= mem_addr[IDX_W-1:0];
        wdata_q <= mem_wdata;
        if (mem_read && mem_write) proto_err <= 1'b1;
      end
      if (ram_re) has_rdata <= 1'b1;
    end
  end

  mem_line_array #(
    .LINE_W (LINE_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .idx   (ram_idx),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  assign mem_ready = (state == MR_RESP);
  assign mem_rdata = has_rdata ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_line_responder.sv
// Scoreboard bench for mem_line_responder: requests push expected responses, a monitor checks them.
module tb_mem_line_responder;

  localparam int unsigned ADDR_W = 28;
  localparam int unsigned LINE_W = 128;
  localparam int RD_LAT = 4;
  localparam int WR_LAT = 4;

  typedef struct {
    bit               rd;
    logic [LINE_W-1:0] data;
    int               cyc;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [LINE_W-1:0] mem_rdata;
  logic              proto_err;

  exp_t sb[$];
  int   cyc;
  int   errors;
  int   checks;
  bit   prev_ready;

  localparam logic [LINE_W-1:0] D1 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  localparam logic [LINE_W-1:0] DA = 128'h11112222_33334444_55556666_77778888;
  localparam logic [LINE_W-1:0] DW = 128'h0F0F0F0F_A5A5A5A5_5A5A5A5A_F0F0F0F0;
  localparam logic [LINE_W-1:0] DX = 128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0;
  localparam logic [LINE_W-1:0] DC = 128'h00C0FFEE_00C0FFEE_00C0FFEE_00C0FFEE;
  localparam logic [LINE_W-1:0] DB = 128'hBBBBBBBB_BBBBBBBB_BBBBBBBB_BBBBBBBB;

  mem_line_responder #(
    .ADDR_W     (ADDR_W),
    .LINE_W     (LINE_W),
    .IDX_W      (8),
    .RD_LAT     (RD_LAT),
    .WR_LAT     (WR_LAT),
    .TURNAROUND (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .proto_err (proto_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    prev_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_ready === 1'b1) begin
        checks++;
        if (prev_ready) begin
          errors++;
          $display("FAIL ready_consecutive: ready high at cyc %0d and previous cycle", cyc);
        end
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ready: ready at cyc %0d with no outstanding request", cyc);
        end else begin
          e = sb.pop_front();
          if (cyc != e.cyc) begin
            errors++;
            $display("FAIL ready_latency: ready at cyc %0d, required cyc %0d", cyc, e.cyc);
          end
          if (e.rd) begin
            checks++;
            if (mem_rdata !== e.data) begin
              errors++;
              $display("FAIL rdata: got %h, required %h", mem_rdata, e.data);
            end
          end
        end
      end
      prev_ready = (mem_ready === 1'b1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  task automatic check_line(input string name, input logic [LINE_W-1:0] act,
                            input logic [LINE_W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Issue one request (DUT assumed idle), wait for ready, optionally lag the release,
  // and return at the first cycle a new request would be accepted without waiting.
  task automatic do_req(input bit rd, input bit wr, input logic [ADDR_W-1:0] addr,
                        input logic [LINE_W-1:0] wd, input logic [LINE_W-1:0] exp_data,
                        input int hold_extra, input int withdraw_after);
    int   c;
    int   r;
    bit   got;
    exp_t e;
    c = cyc;
    mem_read  = rd;
    mem_write = wr;
    mem_addr  = addr;
    mem_wdata = wd;
    e.rd   = rd;
    e.data = exp_data;
    e.cyc  = c + (rd ? RD_LAT : WR_LAT);
    sb.push_back(e);
    got = 1'b0;
    r   = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      if (withdraw_after > 0 && cyc == c + withdraw_after) begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
      if (mem_ready === 1'b1) begin
        got = 1'b1;
        r   = cyc;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ready_timeout: no ready within 40 cycles of request at cyc %0d", c);
      r = cyc;
    end
    for (int i = 0; i < hold_extra; i++) step();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    while (cyc < r + 3) step();
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    cyc       = 0;
    rst       = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    step();
    step();
    check1("reset_ready", mem_ready, 1'b0);
    check_line("reset_rdata", mem_rdata, '0);
    check1("reset_proto_err", proto_err, 1'b0);
    rst = 1'b0;
    step();
    step();

    do_req(1'b0, 1'b1, 28'h0000010, D1, '0, 0, 0);
    do_req(1'b1, 1'b0, 28'h0000010, '0, D1, 0, 0);

    do_req(1'b0, 1'b1, 28'h0000105, DA, '0, 0, 0);
    do_req(1'b1, 1'b0, 28'h0000005, '0, DA, 0, 0);

    // Initiator keeps mem_read high two cycles past ready; next request right at gap end.
    do_req(1'b1, 1'b0, 28'h0000010, '0, D1, 2, 0);
    do_req(1'b1, 1'b0, 28'h0000005, '0, DA, 0, 0);

    do_req(1'b0, 1'b1, 28'h0000030, DW, '0, 0, 1);
    do_req(1'b1, 1'b0, 28'h0000030, '0, DW, 0, 0);

    check1("proto_err_clear", proto_err, 1'b0);
    do_req(1'b1, 1'b1, 28'h0000010, DX, D1, 0, 0);
    check1("proto_err_set", proto_err, 1'b1);
    do_req(1'b1, 1'b0, 28'h0000010, '0, D1, 0, 0);
    check1("proto_err_sticky", proto_err, 1'b1);

    do_req(1'b0, 1'b1, 28'h0000020, DC, '0, 0, 0);

    // Write of B aborted by an asynchronous reset while BUSY.
    mem_write = 1'b1;
    mem_addr  = 28'h0000020;
    mem_wdata = DB;
    step();
    step();
    #3;
    rst = 1'b1;
    #1;
    check1("async_rst_ready", mem_ready, 1'b0);
    check_line("async_rst_rdata", mem_rdata, '0);
    check1("async_rst_proto_err", proto_err, 1'b0);
    mem_write = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step();

    do_req(1'b1, 1'b0, 28'h0000020, '0, DC, 0, 0);
    do_req(1'b1, 1'b0, 28'h0000010, '0, D1, 0, 0);

    for (int i = 0; i < 40 && sb.size() != 0; i++) step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
